pokey_timer_ctrl: RTL and testbench

Sequencer for the four POKEY audio/timer divider channels. It produces the decrement-enable and load strobes for each channel's 8-bit down-counter bit-cell chain and takes back each chain's borrow. It derives the 64 kHz / 15 kHz base clock from the 1.79 MHz machine clock. It applies the AUDCTL clock-source and 16-bit linking rules, handles STIMER restarts, and emits one-cycle channel tick pulses to the polynomial/audio output stage.

---
 rtl/pokey_timer_ctrl_if.sv | 31 +++
 rtl/pokey_timer_ctrl.sv | 102 ++++++++++
 tb/tb_pokey_timer_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pokey_timer_ctrl_if.sv
// Strobe/borrow bundle between the POKEY timer sequencer and its four 8-bit divider chains.
// The master side owns the register inputs and borrows; the slave side produces the strobes.
interface pokey_timer_ctrl_if;
  logic [7:0] audctl;
  logic       stimer;
  logic [3:0] bor;
  logic [3:0] cnt_en;
  logic [3:0] ld;
  logic [3:0] tick;
  logic       base_tick;

  modport master (
    output audctl,
    output stimer,
    output bor,
    input  cnt_en,
    input  ld,
    input  tick,
    input  base_tick
  );

  modport slave (
    input  audctl,
    input  stimer,
    input  bor,
    output cnt_en,
    output ld,
    output tick,
    output base_tick
  );
endinterface

// File: rtl/pokey_timer_ctrl.sv
// POKEY timer sequencer: base-clock prescaler, AUDCTL clock routing and 16-bit linking, STIMER restart.
// Define TIMER_CTRL_FASTCLK_EN to let audctl[6]/audctl[5] clock channels 1/3 every machine cycle.
module pokey_timer_ctrl #(
  parameter int PRESCALE64 = 28,
  parameter int PRESCALE15 = 114
) (
  input  logic               clk,
  input  logic               rst,
  pokey_timer_ctrl_if.slave  bus
);
  localparam int PMAX = (PRESCALE15 > PRESCALE64) ? PRESCALE15 : PRESCALE64;
  localparam int PW   = (PMAX > 2) ? $clog2(PMAX) : 1;
  localparam logic [PW-1:0] TERM64 = PW'(PRESCALE64 - 1);
  localparam logic [PW-1:0] TERM15 = PW'(PRESCALE15 - 1);

  logic [PW-1:0] presc_reg, presc_next;
  logic          sel15_reg, sel15_next;
  logic          base_reg, base_next;
  logic [3:0]    cnt_en_reg, cnt_en_next;
  logic [3:0]    ld_reg, ld_next;
  logic [3:0]    tick_reg, tick_next;

  logic          presc_wrap;
  logic [3:0]    vbor;
  logic [3:0]    src;
  logic [3:0]    reload;
  logic [1:0]    link;

  // The active period is latched at each wrap, so a mode change waits for the current period to end.
  assign presc_wrap = (presc_reg == (sel15_reg ? TERM15 : TERM64));
  assign vbor       = bus.bor & cnt_en_reg;
  assign link       = {bus.audctl[3], bus.audctl[4]};

`ifdef TIMER_CTRL_FASTCLK_EN
  logic unused_audctl;
  assign unused_audctl = ^{bus.audctl[7], bus.audctl[2:1]};
`else
  logic unused_audctl;
  assign unused_audctl = ^{bus.audctl[7:5], bus.audctl[2:1]};
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pair
      localparam int LO = 2 * gi;
      localparam int HI = 2 * gi + 1;
`ifdef TIMER_CTRL_FASTCLK_EN
      // Pair 0 (channel 1) uses audctl[6], pair 1 (channel 3) uses audctl[5].
      assign src[LO] = bus.audctl[6 - gi] | presc_wrap;
`else
      assign src[LO] = presc_wrap;
`endif
      // A linked high channel counts low-channel borrows; its borrow reloads the whole pair.
      assign src[HI]    = link[gi] ? vbor[LO] : presc_wrap;
      assign reload[LO] = link[gi] ? vbor[HI] : vbor[LO];
      assign reload[HI] = vbor[HI];
    end
  endgenerate

  always_comb begin
    presc_next  = presc_wrap ? '0 : presc_reg + PW'(1);
    sel15_next  = presc_wrap ? bus.audctl[0] : sel15_reg;
    base_next   = presc_wrap;
    ld_next     = reload;
    tick_next   = vbor;
    cnt_en_next = src & ~reload;
    if (bus.stimer) begin
      presc_next  = '0;
      sel15_next  = bus.audctl[0];
      base_next   = 1'b0;
      ld_next     = 4'b1111;
      tick_next   = 4'b0000;
      cnt_en_next = 4'b0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg  <= '0;
      sel15_reg  <= 1'b0;
      base_reg   <= 1'b0;
      cnt_en_reg <= 4'b0000;
      ld_reg     <= 4'b0000;
      tick_reg   <= 4'b0000;
    end else begin
      presc_reg  <= presc_next;
      sel15_reg  <= sel15_next;
      base_reg   <= base_next;
      cnt_en_reg <= cnt_en_next;
      ld_reg     <= ld_next;
      tick_reg   <= tick_next;
    end
  end

  assign bus.cnt_en    = cnt_en_reg;
  assign bus.ld        = ld_reg;
  assign bus.tick      = tick_reg;
  assign bus.base_tick = base_reg;

  // A chain must never be asked to load and decrement in the same cycle.
  assert property (@(posedge clk) disable iff (rst) (cnt_en_reg & ld_reg) == 4'b0000);
endmodule

// File: tb/tb_pokey_timer_ctrl.sv
// Bench for pokey_timer_ctrl: behavioural 8-bit chains, a directed vector table, hand-written
// corner sequences and randomized trials checked against closed-form tick timing.
`timescale 1ns/1ps
module tb_pokey_timer_ctrl;
  localparam int P64 = 28;
  localparam int W   = 800;
`ifdef TIMER_CTRL_FASTCLK_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]      audctl;
    logic [3:0][7:0] n;
    logic [1:0]      ch;
    logic [15:0]     first;
    logic [15:0]     period;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;
  logic [7:0] nval [4];
  logic [7:0] cval [4];
  vec_t       tbl [6];

  always #5 clk = ~clk;

  pokey_timer_ctrl_if bus ();
  pokey_timer_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  // Divider chains: consume strobes on the falling edge, borrow when decrementing from zero.
  always @(negedge clk or posedge rst) begin
    if (rst) begin
      bus.bor = 4'b0000;
      for (int i = 0; i < 4; i++) cval[i] = 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        bus.bor[i] = bus.cnt_en[i] && (cval[i] == 8'd0);
        if (bus.ld[i]) cval[i] = nval[i];
        else if (bus.cnt_en[i]) cval[i] = cval[i] - 8'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gap(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.base_tick && n < 400);
  endtask

  task automatic apply(input logic [7:0] a, input logic [3:0][7:0] n);
    bus.audctl = a;
    for (int i = 0; i < 4; i++) nval[i] = n[i];
    bus.stimer = 1'b1;
    step();
    bus.stimer = 1'b0;
  endtask

  task automatic set_vec(input int idx, input logic [7:0] a, input int n0, input int n1,
                         input int n2, input int n3, input int ch, input int first, input int period);
    tbl[idx].audctl = a;
    tbl[idx].n      = {8'(n3), 8'(n2), 8'(n1), 8'(n0)};
    tbl[idx].ch     = 2'(ch);
    tbl[idx].first  = 16'(first);
    tbl[idx].period = 16'(period);
  endtask

  // Tick timing, t cycles after the STIMER load cycle, for one channel of a pair.
  // mode 0: unlinked base-clocked, 1: unlinked with fast low, 2: linked base (high N=0), 3: linked fast low.
  function automatic bit pair_tick(input int mode, input bit hi, input int nlo, input int nhi, input int t);
    int per;
    int u;
    case (mode)
      0: begin
        per = P64 * ((hi ? nhi : nlo) + 1);
        return (t > 1) && ((t - 1) % per == 0);
      end
      1: begin
        if (hi) begin
          per = P64 * (nhi + 1);
          return (t > 1) && ((t - 1) % per == 0);
        end
        return (t > 0) && (t % (nlo + 2) == 0);
      end
      2: begin
        per = P64 * (nlo + 1);
        if (hi) return (t > 2) && ((t - 2) % per == 0);
        return (t > 1) && ((t - 1) % per == 0);
      end
      default: begin
        per = nlo + 3 + 256 * nhi;
        u = t % per;
        if (hi) return (t > 0) && (u == 0);
        return (u >= nlo + 2) && ((u - nlo - 2) % 256 == 0);
      end
    endcase
  endfunction

  initial begin
    int n;
    int cnt;
    int first;
    int second;
    int bad_link;
    int bad_enld;
    int found;
    int mode [2];
    int eff [2];
    int nn [4];
    logic [7:0]      a;
    logic [3:0][7:0] nv;
    logic [3:0]      et;
    logic [3:0]      el;
    bit              th;
    bit              tl;

    bus.audctl = 8'h00;
    bus.stimer = 1'b0;
    for (int i = 0; i < 4; i++) nval[i] = 8'd0;

    set_vec(0, 8'h00, 3, 0, 0, 0, 0, 113, 112);
    set_vec(1, 8'h00, 0, 0, 0, 0, 3, 29, 28);
    set_vec(2, 8'h10, 1, 0, 0, 0, 1, 58, 56);
    if (FAST) begin
      set_vec(3, 8'h40, 10, 0, 0, 0, 0, 12, 12);
      set_vec(4, 8'h20, 0, 0, 5, 0, 2, 7, 7);
      set_vec(5, 8'h50, 0, 1, 0, 0, 1, 259, 259);
    end else begin
      set_vec(3, 8'h40, 10, 0, 0, 0, 0, 309, 308);
      set_vec(4, 8'h20, 0, 0, 5, 0, 2, 169, 168);
      set_vec(5, 8'h08, 0, 0, 0, 0, 3, 30, 28);
    end

    // Reset: outputs quiet, first base_tick P clocks after release, no load on release.
    repeat (3) begin
      step();
      check("rst_outputs", {bus.cnt_en, bus.ld, bus.tick, bus.base_tick}, 13'h0);
    end
    rst = 1'b0;
    n = 0;
    cnt = 0;
    do begin
      step();
      n++;
      if (bus.ld != 4'b0000) cnt++;
    end while (!bus.base_tick && n < 400);
    check("first_base", n, 28);
    check("no_ld_on_release", cnt, 0);
    gap(n);
    check("base_gap64", n, 28);
    $display("txn reset: base_tick period %0d", n);

    // 15 kHz select only takes effect from the next wrap, in both directions.
    bus.audctl = 8'h01;
    gap(n);
    check("gap_pending15", n, 28);
    gap(n);
    check("gap15", n, 114);
    $display("txn audctl=01: base_tick period %0d", n);
    bus.audctl = 8'h00;
    gap(n);
    check("gap_pending64", n, 114);
    gap(n);
    check("gap64_again", n, 28);
    $display("txn audctl=00: base_tick period %0d", n);

    // Directed vectors: first tick offset and period after STIMER.
    for (int v = 0; v < 6; v++) begin
      first = -1;
      second = -1;
      bad_link = 0;
      bad_enld = 0;
      apply(tbl[v].audctl, tbl[v].n);
      check("vec_stimer_ld", bus.ld, 4'hF);
      check("vec_stimer_tick", bus.tick, 4'h0);
      for (int t = 1; t <= 1000 && second < 0; t++) begin
        step();
        if (bus.tick[tbl[v].ch]) begin
          if (first < 0) first = t;
          else second = t;
        end
        if ((bus.cnt_en & bus.ld) != 4'b0000) bad_enld++;
        if (tbl[v].audctl[4] && (bus.ld[0] != bus.ld[1])) bad_link++;
        if (tbl[v].audctl[3] && (bus.ld[2] != bus.ld[3])) bad_link++;
      end
      check("vec_first_tick", first, 32'(tbl[v].first));
      check("vec_period", (second < 0) ? -1 : second - first, 32'(tbl[v].period));
      check("vec_en_in_ld", bad_enld, 0);
      check("vec_pair_ld", bad_link, 0);
      $display("txn vec %0d audctl=%02h ch=%0d first=%0d period=%0d", v, tbl[v].audctl,
               tbl[v].ch + 1, first, (second < 0) ? -1 : second - first);
    end

    // STIMER in the same cycle as a channel-2 borrow.
    apply(8'h00, {8'd0, 8'd0, 8'd0, 8'd0});
    found = 0;
    for (int t = 0; t < 100 && found == 0; t++) begin
      step();
      if (bus.base_tick && bus.cnt_en[1]) found = 1;
    end
    check("collide_wait", found, 1);
    bus.stimer = 1'b1;
    step();
    bus.stimer = 1'b0;
    check("collide_ld", bus.ld, 4'hF);
    check("collide_tick", bus.tick, 4'h0);
    check("collide_en", bus.cnt_en, 4'h0);
    gap(n);
    check("collide_base", n, 28);
    $display("txn stimer+borrow: ld=%h next base after %0d", 4'hF, n);

    // Randomized trials against closed-form timing.
    for (int tr = 0; tr < 8; tr++) begin
      a = 8'h00;
      for (int p = 0; p < 2; p++) begin
        mode[p] = int'($urandom_range(0, 3));
        case (mode[p])
          0: begin nn[2*p] = int'($urandom_range(0, 5)); nn[2*p+1] = int'($urandom_range(0, 5)); end
          1: begin
            nn[2*p] = FAST ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5));
            nn[2*p+1] = int'($urandom_range(0, 5));
          end
          2: begin nn[2*p] = int'($urandom_range(0, 5)); nn[2*p+1] = 0; end
          default: begin
            nn[2*p] = FAST ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5));
            nn[2*p+1] = FAST ? int'($urandom_range(0, 2)) : 0;
          end
        endcase
        if (mode[p] >= 2) a[p == 0 ? 4 : 3] = 1'b1;
        if (mode[p] == 1 || mode[p] == 3) a[p == 0 ? 6 : 5] = 1'b1;
        eff[p] = mode[p];
        if (!FAST && mode[p] == 1) eff[p] = 0;
        if (!FAST && mode[p] == 3) eff[p] = 2;
      end
      for (int i = 0; i < 4; i++) nv[i] = 8'(nn[i]);
      $display("txn rnd %0d audctl=%02h n=%0d,%0d,%0d,%0d", tr, a, nn[0], nn[1], nn[2], nn[3]);
      apply(a, nv);
      check("rnd_stimer_ld", bus.ld, 4'hF);
      check("rnd_stimer_tick", bus.tick, 4'h0);
      for (int t = 1; t < W; t++) begin
        step();
        for (int p = 0; p < 2; p++) begin
          tl = pair_tick(eff[p], 1'b0, nn[2*p], nn[2*p+1], t);
          th = pair_tick(eff[p], 1'b1, nn[2*p], nn[2*p+1], t);
          et[2*p]   = tl;
          et[2*p+1] = th;
          el[2*p]   = (eff[p] >= 2) ? th : tl;
          el[2*p+1] = th;
        end
        check("rnd_tick", bus.tick, et);
        check("rnd_ld", bus.ld, el);
        check("rnd_base", bus.base_tick, (t % P64 == 0) ? 1 : 0);
        check("rnd_en_in_ld", bus.cnt_en & bus.ld, 4'h0);
      end
    end

    // Reset mid-operation clears everything at once; prescaler restarts from zero.
    #2 rst = 1'b1;
    #1;
    check("async_rst", {bus.cnt_en, bus.ld, bus.tick, bus.base_tick}, 13'h0);
    step();
    step();
    check("rst_hold", {bus.cnt_en, bus.ld, bus.tick, bus.base_tick}, 13'h0);
    rst = 1'b0;
    gap(n);
    check("rst_restart_base", n, 28);
    $display("txn mid reset: first base_tick after %0d", n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
